config_writer: RTL

CONFIG_WRITER -- requirements
Module: config_writer

---
 rtl/config_pkg.sv | 28 ++
 rtl/config_timeout_ctr.sv | 30 +++
 rtl/config_writer.sv | 117 +++++++++++
 3 files changed

// File: rtl/config_pkg.sv
// Shared definitions for the config writer and the config register it targets:
// default field widths, message bit offsets and the writer FSM state encoding.
package config_pkg;

    localparam int ADDR_W    = 4;
    localparam int PAYLOAD_W = 8;

    // Message layout, MSB first: {addr, flag, payload}
    function automatic int flag_bit(input int payload_w);
        return payload_w;
    endfunction

    function automatic int addr_lsb(input int payload_w);
        return payload_w + 1;
    endfunction

    function automatic int msg_w(input int addr_w, input int payload_w);
        return addr_w + payload_w + 1;
    endfunction

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND   = 2'd1,
        WAIT   = 2'd2,
        REPORT = 2'd3
    } state_t;

endpackage

// File: rtl/config_timeout_ctr.sv
// Response timeout counter: counts enabled cycles from a clear, flags the last one.
// expired is combinational from the count, so it is seen in the TIMEOUT-th enabled cycle.
module config_timeout_ctr #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/config_writer.sv
// Writes one config register per command, retrying on mismatch or timeout, then reports.
// Handshake outputs are Moore (state only); each stage holds until its partner is ready.
module config_writer
    import config_pkg::*;
#(
    parameter int ADDR_SIZE    = ADDR_W,
    parameter int PAYLOAD_SIZE = PAYLOAD_W,
    parameter int TIMEOUT      = 16,
    parameter int MAX_RETRIES  = 2,
    localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              cmd_val,
    output logic                              cmd_rdy,
    input  logic [ADDR_SIZE-1:0]              cmd_addr,
    input  logic [PAYLOAD_SIZE-1:0]           cmd_payload,
    output logic                              send_val,
    input  logic                              send_rdy,
    output logic [ADDR_SIZE+PAYLOAD_SIZE:0]   send_msg,
    input  logic                              recv_val,
    output logic                              recv_rdy,
    input  logic [ADDR_SIZE+PAYLOAD_SIZE:0]   recv_msg,
    output logic                              status_val,
    input  logic                              status_rdy,
    output logic                              status_ok,
    output logic [RW-1:0]                     status_retries
);

    localparam int MW       = msg_w(ADDR_SIZE, PAYLOAD_SIZE);
    localparam int FLAG_BIT = flag_bit(PAYLOAD_SIZE);
    localparam int ADDR_LSB = addr_lsb(PAYLOAD_SIZE);
    localparam logic [RW-1:0] MAX_R = RW'(MAX_RETRIES);

    state_t                  state;
    logic [ADDR_SIZE-1:0]    addr_q;
    logic [PAYLOAD_SIZE-1:0] payload_q;
    logic [RW-1:0]           retries;
    logic                    ok_q;

    logic expired;
    logic tmr_clear;
    logic tmr_en;
    logic match;
    logic fail;

    assign match = (recv_msg[MW-1:ADDR_LSB] == addr_q) && recv_msg[FLAG_BIT]
                && (recv_msg[PAYLOAD_SIZE-1:0] == payload_q);

    // A response in the expiry cycle is judged on its content, not the timer
    assign fail      = (state == WAIT) && (recv_val ? !match : expired);
    assign tmr_clear = (state == SEND) && send_rdy;
    assign tmr_en    = (state == WAIT) && !recv_val;

    config_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (tmr_clear),
        .enable  (tmr_en),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            addr_q    <= '0;
            payload_q <= '0;
            retries   <= '0;
            ok_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_val) begin
                        addr_q    <= cmd_addr;
                        payload_q <= cmd_payload;
                        retries   <= '0;
                        ok_q      <= 1'b0;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    if (send_rdy) state <= WAIT;
                end
                WAIT: begin
                    if (recv_val && match) begin
                        ok_q  <= 1'b1;
                        state <= REPORT;
                    end else if (fail) begin
                        if (retries < MAX_R) begin
                            retries <= retries + 1'b1;
                            state   <= SEND;
                        end else begin
                            ok_q  <= 1'b0;
                            state <= REPORT;
                        end
                    end
                end
                REPORT: begin
                    if (status_rdy) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs are forced low while reset is held, whatever the old state was
    assign cmd_rdy        = !reset && (state == IDLE);
    assign send_val       = !reset && (state == SEND);
    assign recv_rdy       = !reset && (state == WAIT);
    assign status_val     = !reset && (state == REPORT);
    assign send_msg       = send_val ? {addr_q, 1'b1, payload_q} : '0;
    assign status_ok      = status_val && ok_q;
    assign status_retries = status_val ? retries : '0;

endmodule
